// File: rtl/roulette_multimode_engine_if.sv
// Bet/result bundle between the switch/LFSR front end and the roulette engine.
interface roulette_multimode_engine_if #(
    parameter int NUM_W = 5,
    parameter int BAL_W = 8
);
    logic             spin;
    logic [1:0]       mode;
    logic [NUM_W-1:0] guess;
    logic [NUM_W-1:0] randnum;
    logic [BAL_W-1:0] balance;
    logic [1:0]       game_state;
    logic             result_valid;
    logic             last_win;
    logic             bad_bet;
    logic             win_led;
    logic             lose_led;

    modport master (
        output spin, mode, guess, randnum,
        input  balance, game_state, result_valid, last_win, bad_bet, win_led, lose_led
    );

    modport slave (
        input  spin, mode, guess, randnum,
        output balance, game_state, result_valid, last_win, bad_bet, win_led, lose_led
    );
endinterface

// File: rtl/roulette_multimode_engine.sv
// Roulette betting engine: parity, high/low and exact-number bets with balance tracking.
// Exact-number bets (mode 10) are built only when ROULETTE_EXACT_BET_EN is defined.
module roulette_multimode_engine #(
    parameter int NUM_W     = 5,
    parameter int BAL_W     = 8,
    parameter int START_BAL = 10,
    parameter int WIN_BAL   = 20,
    parameter int PAY_EVEN  = 2,
    parameter int PAY_EXACT = 16,
    parameter int STAKE     = 1
) (
    input logic                     clk,
    input logic                     reset_n,
    roulette_multimode_engine_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        LOST = 2'b10,
        WON  = 2'b11
    } state_t;

    localparam logic [BAL_W:0]   BAL_MAX     = {1'b0, {BAL_W{1'b1}}};
    localparam logic [BAL_W:0]   PAY_EVEN_W  = (BAL_W+1)'(PAY_EVEN);
    localparam logic [BAL_W:0]   PAY_EXACT_W = (BAL_W+1)'(PAY_EXACT);
    localparam logic [BAL_W:0]   STAKE_W     = (BAL_W+1)'(STAKE);
    localparam logic [BAL_W:0]   WIN_BAL_W   = (BAL_W+1)'(WIN_BAL);
    localparam logic [BAL_W-1:0] START_BAL_W = BAL_W'(START_BAL);

    state_t           state;
    state_t           play_next;
    logic [BAL_W-1:0] balance;
    logic             spin_q;
    logic             spin_edge;
    logic             last_win;
    logic             result_valid;
    logic             bad_bet;
    logic             win_led;
    logic             lose_led;
    logic             mode_ok;
    logic             bet_win;
    logic [BAL_W:0]   credit;
    logic [BAL_W:0]   bal_wide;
    logic [BAL_W:0]   sum_wide;
    logic [BAL_W:0]   new_bal_wide;

    assign spin_edge = bus.spin & ~spin_q;

    // Zero is the house number: it beats every parity and high/low bet.
    always_comb begin
        mode_ok = 1'b0;
        bet_win = 1'b0;
        case (bus.mode)
            2'b00: begin
                mode_ok = 1'b1;
                bet_win = (bus.randnum != '0) && (bus.randnum[0] == ~bus.guess[0]);
            end
            2'b01: begin
                mode_ok = 1'b1;
                bet_win = (bus.randnum != '0) && (bus.randnum[NUM_W-1] == bus.guess[0]);
            end
`ifdef ROULETTE_EXACT_BET_EN
            2'b10: begin
                mode_ok = 1'b1;
                bet_win = (bus.randnum == bus.guess);
            end
`endif
            default: begin
                mode_ok = 1'b0;
                bet_win = 1'b0;
            end
        endcase
    end

    // Saturating balance arithmetic one bit wider than the register.
    always_comb begin
        credit   = (bus.mode == 2'b10) ? PAY_EXACT_W : PAY_EVEN_W;
        bal_wide = {1'b0, balance};
        sum_wide = bal_wide + credit;
        if (bet_win)
            new_bal_wide = (sum_wide > BAL_MAX) ? BAL_MAX : sum_wide;
        else
            new_bal_wide = (bal_wide < STAKE_W) ? '0 : (bal_wide - STAKE_W);
        if (new_bal_wide >= WIN_BAL_W)
            play_next = WON;
        else if (new_bal_wide == '0)
            play_next = LOST;
        else
            play_next = PLAY;
    end

    // spin_q resets high so a key held through reset does not count as a press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            balance      <= START_BAL_W;
            spin_q       <= 1'b1;
            last_win     <= 1'b0;
            result_valid <= 1'b0;
            bad_bet      <= 1'b0;
            win_led      <= 1'b0;
            lose_led     <= 1'b0;
        end else begin
            spin_q       <= bus.spin;
            result_valid <= 1'b0;
            bad_bet      <= 1'b0;
            if (spin_edge) begin
                case (state)
                    IDLE: begin
                        balance <= START_BAL_W;
                        state   <= PLAY;
                    end
                    PLAY: begin
                        if (mode_ok) begin
                            balance      <= new_bal_wide[BAL_W-1:0];
                            last_win     <= bet_win;
                            result_valid <= 1'b1;
                            state        <= play_next;
                            win_led      <= (play_next == WON);
                            lose_led     <= (play_next == LOST);
                        end else begin
                            bad_bet <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        win_led  <= 1'b0;
                        lose_led <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.balance      = balance;
    assign bus.game_state   = state;
    assign bus.result_valid = result_valid;
    assign bus.last_win     = last_win;
    assign bus.bad_bet      = bad_bet;
    assign bus.win_led      = win_led;
    assign bus.lose_led     = lose_led;

endmodule

// File: tb/tb_roulette_multimode_engine.sv
// Self-checking bench for roulette_multimode_engine: directed vector table, corner sequences
// and a randomized run against a rule-level reference model.
module tb_roulette_multimode_engine;

`ifdef ROULETTE_EXACT_BET_EN
    localparam bit EXACT_EN = 1'b1;
`else
    localparam bit EXACT_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0] mode;
        logic [4:0] guess;
        logic [4:0] randnum;
        int         exp_bal;
        int         exp_state;
        int         exp_lw;
        int         exp_rv;
        int         exp_bb;
    } vec_t;

    logic clk;
    logic reset_n;
    int   assertions;
    int   failures;

    int   m_state;
    int   m_bal;
    int   m_lw;
    int   exp_rv;
    int   exp_bb;

    roulette_multimode_engine_if #(.NUM_W(5), .BAL_W(8)) bus ();

    roulette_multimode_engine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string name, input int act, input int exp);
        assertions++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input int bal, input int st, input int lw,
                               input int rv, input int bb);
        checkField({name, ".balance"}, int'(bus.balance), bal);
        checkField({name, ".state"}, int'(bus.game_state), st);
        checkField({name, ".last_win"}, int'(bus.last_win), lw);
        checkField({name, ".result_valid"}, int'(bus.result_valid), rv);
        checkField({name, ".bad_bet"}, int'(bus.bad_bet), bb);
        checkField({name, ".win_led"}, int'(bus.win_led), (st == 3) ? 1 : 0);
        checkField({name, ".lose_led"}, int'(bus.lose_led), (st == 2) ? 1 : 0);
    endtask

    // Drops spin for one clock, then presents a fresh press; returns once the result is visible.
    task automatic applyStimulus(input logic [1:0] m, input logic [4:0] g, input logic [4:0] r);
        bus.spin = 1'b0;
        @(negedge clk);
        bus.mode    = m;
        bus.guess   = g;
        bus.randnum = r;
        bus.spin    = 1'b1;
        @(negedge clk);
    endtask

    task automatic doReset();
        bus.spin = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        m_state = 0;
        m_bal   = 10;
        m_lw    = 0;
    endtask

    // Reference model straight from the game rules, in plain integer arithmetic.
    task automatic modelStep(input int m, input int g, input int r);
        bit valid;
        bit win;
        exp_rv = 0;
        exp_bb = 0;
        if (m_state == 0) begin
            m_bal   = 10;
            m_state = 1;
        end else if (m_state == 1) begin
            valid = (m == 0) || (m == 1) || (m == 2 && EXACT_EN);
            if (!valid) begin
                exp_bb = 1;
            end else begin
                if (m == 0)
                    win = (r != 0) && ((r % 2 == 0) == (g % 2 == 1));
                else if (m == 1)
                    win = (r != 0) && ((r >= 16) == (g % 2 == 1));
                else
                    win = (r == g);
                if (win)
                    m_bal = (m_bal + ((m == 2) ? 16 : 2) > 255) ? 255 : m_bal + ((m == 2) ? 16 : 2);
                else
                    m_bal = (m_bal > 0) ? m_bal - 1 : 0;
                m_lw   = win ? 1 : 0;
                exp_rv = 1;
                if (m_bal >= 20)
                    m_state = 3;
                else if (m_bal == 0)
                    m_state = 2;
            end
        end else begin
            m_state = 0;
        end
    endtask

    task automatic modelSpin(input string name, input logic [1:0] m, input logic [4:0] g,
                             input logic [4:0] r);
        applyStimulus(m, g, r);
        modelStep(int'(m), int'(g), int'(r));
        checkOutput(name, m_bal, m_state, m_lw, exp_rv, exp_bb);
    endtask

    vec_t vecs[9];
    int   rv_count;

    initial begin
        assertions  = 0;
        failures    = 0;
        bus.spin    = 1'b0;
        bus.mode    = 2'b00;
        bus.guess   = '0;
        bus.randnum = '0;
        reset_n     = 1'b0;

        vecs[0] = '{2'b00, 5'd1, 5'd6,  10, 1, 0, 0, 0};
        vecs[1] = '{2'b00, 5'd1, 5'd6,  12, 1, 1, 1, 0};
        vecs[2] = '{2'b00, 5'd0, 5'd0,  11, 1, 0, 1, 0};
        vecs[3] = '{2'b01, 5'd1, 5'd20, 13, 1, 1, 1, 0};
        vecs[4] = '{2'b01, 5'd0, 5'd16, 12, 1, 0, 1, 0};
        vecs[5] = '{2'b01, 5'd0, 5'd15, 14, 1, 1, 1, 0};
        vecs[6] = '{2'b00, 5'd0, 5'd7,  16, 1, 1, 1, 0};
        vecs[7] = '{2'b11, 5'd0, 5'd7,  16, 1, 1, 0, 1};
        if (EXACT_EN)
            vecs[8] = '{2'b10, 5'd7, 5'd7, 32, 3, 1, 1, 0};
        else
            vecs[8] = '{2'b10, 5'd7, 5'd7, 16, 1, 1, 0, 1};

        // Spin held through reset must not start a game on release.
        bus.spin = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", 10, 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].guess, vecs[i].randnum);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_bal, vecs[i].exp_state,
                        vecs[i].exp_lw, vecs[i].exp_rv, vecs[i].exp_bb);
        end

        $display("[TB] win threshold sequence");
        doReset();
        modelSpin("win_start", 2'b00, 5'd0, 5'd0);
        for (int i = 0; i < 5; i++)
            modelSpin($sformatf("win_step%0d", i), 2'b01, 5'd1, 5'd20);
        checkOutput("won", 20, 3, 1, 1, 0);
        modelSpin("won_to_idle", 2'b01, 5'd1, 5'd20);
        checkField("won_frozen.balance", int'(bus.balance), 20);
        modelSpin("idle_restart", 2'b00, 5'd1, 5'd6);
        checkField("restart.balance", int'(bus.balance), 10);

        $display("[TB] lose sequence");
        doReset();
        modelSpin("lose_start", 2'b00, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++)
            modelSpin($sformatf("lose_step%0d", i), 2'b00, 5'd1, 5'd0);
        checkOutput("lost", 0, 2, 0, 1, 0);
        modelSpin("lost_to_idle", 2'b00, 5'd1, 5'd6);
        checkOutput("lost_idle", 0, 0, 0, 0, 0);
        modelSpin("lost_restart", 2'b00, 5'd1, 5'd6);
        checkOutput("lost_restart", 10, 1, 0, 0, 0);

        $display("[TB] held spin");
        bus.spin = 1'b0;
        @(negedge clk);
        bus.mode    = 2'b01;
        bus.guess   = 5'd1;
        bus.randnum = 5'd20;
        bus.spin    = 1'b1;
        rv_count    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.result_valid) rv_count++;
        end
        checkField("held.pulses", rv_count, 1);
        checkField("held.balance", int'(bus.balance), 12);

        $display("[TB] reset during update");
        bus.spin = 1'b0;
        @(negedge clk);
        bus.spin = 1'b1;
        reset_n  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("rst_update", 10, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_held", 10, 0, 0, 0, 0);

        $display("[TB] randomized run");
        doReset();
        for (int i = 0; i < 300; i++)
            modelSpin($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
